// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg: op codes, default latencies and state types shared by mul_div_unit
package mul_div_unit_pkg;
  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MADD  = 3'b100;
  localparam logic [2:0] OP_MADDU = 3'b101;
  localparam logic [2:0] OP_MSUB  = 3'b110;
  localparam logic [2:0] OP_MSUBU = 3'b111;
  localparam int MUL_LAT_DEF = 5;
  localparam int DIV_LAT_DEF = 10;
  typedef enum logic {S_IDLE, S_BUSY} state_t;
  typedef enum logic [1:0] {ACC_LOAD, ACC_ADD, ACC_SUB} acc_t;
endpackage

// File: rtl/mul_div_unit_div_core.sv
// mul_div_unit_div_core: combinational signed/unsigned divide with divide-by-zero and overflow rules
module mul_div_unit_div_core #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sgn,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);
  logic             na, nb;
  logic [WIDTH-1:0] ua, ub, uq, ur;
  assign na = sgn & a[WIDTH-1];
  assign nb = sgn & b[WIDTH-1];
  assign ua = na ? -a : a;
  assign ub = nb ? -b : b;
  // INT_MIN / -1 falls out naturally: |INT_MIN| / 1 negated wraps back to INT_MIN, remainder 0
  assign uq = (ub == '0) ? '0 : ua / ub;
  assign ur = (ub == '0) ? '0 : ua % ub;
  assign q = (b == '0) ? '1 : (na ^ nb) ? -uq : uq;
  assign r = (b == '0) ? a : na ? -ur : ur;
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle multiply/divide with HI/LO; MUL_DIV_MADD_EN adds madd/maddu/msub/msubu
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic             we,
  input  logic             hilo,
  input  logic             flush,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2((MUL_LAT > DIV_LAT ? MUL_LAT : DIV_LAT) + 1);
  state_t              state, state_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic                is_mul, is_div, is_mac, go, commit;
  logic [WIDTH-1:0]    q, r;
  logic [2*WIDTH-1:0]  xa, xb, prod, res, pend, acc;
  assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div = (op == OP_DIV) || (op == OP_DIVU);
`ifdef MUL_DIV_MADD_EN
  acc_t mode;
  assign is_mac = op[2];
  assign acc = (mode == ACC_ADD) ? {hi, lo} + pend : (mode == ACC_SUB) ? {hi, lo} - pend : pend;
`else
  assign is_mac = 1'b0;
  assign acc = pend;
`endif
  assign go = start & ~flush & (state == S_IDLE) & (is_mul | is_div | is_mac);
  assign busy = (state == S_BUSY);
  // op[0] selects unsigned for every multiply-class op; the 2*WIDTH product is exact either way
  assign xa = {{WIDTH{~op[0] & d1[WIDTH-1]}}, d1};
  assign xb = {{WIDTH{~op[0] & d2[WIDTH-1]}}, d2};
  assign prod = xa * xb;
  assign res = is_div ? {r, q} : prod;
  mul_div_unit_div_core #(.WIDTH(WIDTH)) u_div (
    .a(d1),
    .b(d2),
    .sgn(~op[0]),
    .q(q),
    .r(r)
  );
  // state register and busy counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  end
  // next state: launch, count down, commit on the last busy cycle, or abort on flush
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    commit = 1'b0;
    if (state == S_IDLE) begin
      if (go) begin
        state_n = S_BUSY;
        cnt_n = is_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
      end
    end else if (flush) begin
      state_n = S_IDLE;
      cnt_n = '0;
    end else if (cnt == CW'(1)) begin
      state_n = S_IDLE;
      cnt_n = '0;
      commit = 1'b1;
    end else begin
      cnt_n = cnt - 1'b1;
    end
  end
  // result is computed at launch into pend; HI/LO only change on commit or an idle mthi/mtlo
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
      hi <= '0;
      lo <= '0;
`ifdef MUL_DIV_MADD_EN
      mode <= ACC_LOAD;
`endif
    end else begin
      if (go) pend <= res;
`ifdef MUL_DIV_MADD_EN
      if (go) mode <= !is_mac ? ACC_LOAD : (op == OP_MSUB || op == OP_MSUBU) ? ACC_SUB : ACC_ADD;
`endif
      if (commit) {hi, lo} <= acc;
      else if (we & ~start & (state == S_IDLE)) begin
        if (hilo) hi <= d1;
        else lo <= d1;
      end
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: table, hand-written corner sequences and random ops against a reference model
module tb_mul_div_unit;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, we = 1'b0, hilo = 1'b0, flush = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] d1 = '0, d2 = '0;
  logic        busy;
  logic [31:0] hi, lo;
  logic [31:0] m_hi = '0, m_lo = '0;
  int vectors = 0, miscompares = 0;

  mul_div_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .d1(d1), .d2(d2),
    .we(we), .hilo(hilo), .flush(flush), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, h, l;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int lat(input logic [2:0] o);
    if (o == 3'd2 || o == 3'd3) return 10;
    if (o == 3'd0 || o == 3'd1) return 5;
`ifdef MUL_DIV_MADD_EN
    return 5;
`else
    return 0;
`endif
  endfunction

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                        input logic [63:0] cur);
    int sa, sb, qq, rr;
    longint sp;
    logic [63:0] up;
    sa = a;
    sb = b;
    sp = longint'(sa) * longint'(sb);
    up = {32'd0, a} * {32'd0, b};
    case (o)
      3'd0: return sp;
      3'd1: return up;
      3'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && sb == -1) return {32'd0, 32'h8000_0000};
        qq = sa / sb;
        rr = sa % sb;
        return {rr, qq};
      end
      3'd3: return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
`ifdef MUL_DIV_MADD_EN
      3'd4: return cur + sp;
      3'd5: return cur + up;
      3'd6: return cur - sp;
      3'd7: return cur - up;
`endif
      default: return cur;
    endcase
  endfunction

  task automatic mt(input logic h, input logic [31:0] v);
    @(negedge clk);
    we = 1'b1;
    hilo = h;
    d1 = v;
    @(negedge clk);
    we = 1'b0;
    if (h) m_hi = v;
    else m_lo = v;
  endtask

  task automatic run(input string name, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [63:0] exp);
    int n;
    @(negedge clk);
    start = 1'b1;
    op = o;
    d1 = a;
    d2 = b;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk({name, " latency"}, 64'(n), 64'(lat(o)));
    chk({name, " hi:lo"}, {hi, lo}, exp);
    {m_hi, m_lo} = exp;
  endtask

  initial begin
    vec_t tab[9];
    int n;
    logic [2:0] o;
    logic [31:0] a, b;
    tab[0] = '{3'd0, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
    tab[1] = '{3'd1, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE};
    tab[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tab[3] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    tab[4] = '{3'd3, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF};
    tab[5] = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    tab[6] = '{3'd2, 32'd5,         32'd0,         32'h0000_0005, 32'hFFFF_FFFF};
    tab[7] = '{3'd3, 32'hFFFF_FFFF, 32'd10,        32'h0000_0005, 32'h1999_9999};
    tab[8] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};

    #3;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset hi:lo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run($sformatf("table[%0d]", i), tab[i].op, tab[i].a, tab[i].b, {tab[i].h, tab[i].l});

    mt(1'b1, 32'h0000_AAAA);
    chk("mthi", {hi, lo}, {32'h0000_AAAA, m_lo});
    mt(1'b0, 32'h0000_5555);
    chk("mtlo", {hi, lo}, {32'h0000_AAAA, 32'h0000_5555});

    // start and we during busy cycle 3 of a div are ignored
    @(negedge clk);
    start = 1'b1; op = 3'd2; d1 = 32'd100; d2 = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; op = 3'd0; d1 = 32'd3; d2 = 32'd3; we = 1'b1; hilo = 1'b1;
    @(negedge clk);
    start = 1'b0; we = 1'b0;
    chk("we while busy", {hi, lo}, {32'h0000_AAAA, 32'h0000_5555});
    n = 3;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("mid-op latency", 64'(n), 64'd10);
    chk("mid-op result", {hi, lo}, {32'd2, 32'd14});
    m_hi = 32'd2; m_lo = 32'd14;

    // flush in busy cycle 3 aborts without commit
    @(negedge clk);
    start = 1'b1; op = 3'd3; d1 = 32'd999; d2 = 32'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush busy", 64'(busy), 64'd0);
    repeat (12) @(negedge clk);
    chk("flush no commit", {hi, lo}, {m_hi, m_lo});

    // flush together with start from idle: start is dropped
    start = 1'b1; flush = 1'b1; op = 3'd1; d1 = 32'd9; d2 = 32'd9;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush+start busy", 64'(busy), 64'd0);
    repeat (6) @(negedge clk);
    chk("flush+start hi:lo", {hi, lo}, {m_hi, m_lo});

    // we together with start: write ignored, op runs
    start = 1'b1; we = 1'b1; hilo = 1'b0; op = 3'd1; d1 = 32'd6; d2 = 32'd7;
    @(negedge clk);
    start = 1'b0; we = 1'b0;
    chk("we+start no write", {hi, lo}, {m_hi, m_lo});
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("we+start latency", 64'(n), 64'd5);
    chk("we+start result", {hi, lo}, {32'd0, 32'd42});
    m_hi = 32'd0; m_lo = 32'd42;

`ifdef MUL_DIV_MADD_EN
    mt(1'b1, 32'd0);
    mt(1'b0, 32'd10);
    run("madd", 3'd4, 32'd3, 32'd4, {32'd0, 32'd22});
    run("msubu", 3'd7, 32'd1, 32'd23, 64'hFFFF_FFFF_FFFF_FFFF);
`else
    run("undef op 100", 3'd4, 32'd3, 32'd4, {m_hi, m_lo});
    run("undef op 111", 3'd7, 32'd1, 32'd23, {m_hi, m_lo});
`endif

    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 3));
`ifdef MUL_DIV_MADD_EN
      if ($urandom_range(0, 3) == 0) o = 3'($urandom_range(4, 7));
`endif
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      if ($urandom_range(0, 3) == 0) mt(1'($urandom_range(0, 1)), $urandom);
      run($sformatf("random[%0d] op%0d", i, o), o, a, b, model(o, a, b, {m_hi, m_lo}));
    end

    // async reset mid-op clears everything immediately
    mt(1'b1, 32'h1357_9BDF);
    @(negedge clk);
    start = 1'b1; op = 3'd2; d1 = 32'd50; d2 = 32'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async rst busy", 64'(busy), 64'd0);
    chk("async rst hi:lo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("post-rst idle", {63'd0, busy, hi, lo} , 128'd0 == 128'd0 ? 64'd0 : 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
